// File: rtl/fix_session_pkg.sv
// Shared FIX session definitions: message-type codes, scheduler FSM states and the queued order record.
// Default widths stand in for the HOST_ADDR_WIDTH / VALUE_DATA_WIDTH / VALUE_SIZE build settings.
package fix_session_pkg;

    localparam int HOST_ADDR_WIDTH  = 4;
    localparam int VALUE_DATA_WIDTH = 16;
    localparam int VALUE_SIZE       = 4;

    localparam logic [3:0] MSG_LOGON      = 4'hA;
    localparam logic [3:0] MSG_LOGOUT     = 4'h5;
    localparam logic [3:0] MSG_HEARTBEAT  = 4'h0;
    localparam logic [3:0] MSG_RESEND_REQ = 4'h2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_ISSUE,
        ST_WAIT_DONE
    } sched_state_e;

    typedef struct packed {
        logic [3:0]                 msg_type;
        logic [HOST_ADDR_WIDTH-1:0] host;
    } order_t;

endpackage

// File: rtl/create_msg_scheduler_sync_fifo.sv
// Single-clock show-ahead FIFO; pop_data always presents the oldest entry.
// A push is taken while full only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/create_msg_scheduler.sv
// Round-robin order queue in front of create_message: arbitrates requesters, looks up targetCompId, issues one order at a time.
// Optional HB_COALESCE_EN drops duplicate heartbeats for a host that already has one queued.
module create_msg_scheduler
    import fix_session_pkg::*;
#(
    parameter int NUM_HOST    = HOST_ADDR_WIDTH,
    parameter int VALUE_WIDTH = VALUE_DATA_WIDTH,
    parameter int SIZE        = VALUE_SIZE,
    parameter int NUM_REQ     = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int DONE_TMO    = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*4-1:0]        req_type_i,
    input  logic [NUM_REQ*NUM_HOST-1:0] req_host_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_HOST-1:0]         addr_o,
    input  logic [VALUE_WIDTH+SIZE-1:0] data_i,
    input  logic                        cm_done_i,
    output logic                        initiate_msg_o,
    output logic [3:0]                  create_message_o,
    output logic [VALUE_WIDTH-1:0]      targetCompId_o,
    output logic [SIZE-1:0]             s_v_targetCompId_o,
    output logic [NUM_HOST-1:0]         host_o,
    output logic                        busy_o,
    output logic                        tmo_err_o
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int ORDER_W = 4 + NUM_HOST;
    localparam int WD_W    = $clog2(DONE_TMO + 1);

    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    next_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic                grant_found;
    int                  grant_idx;
    logic                accept;
    logic [3:0]          acc_type;
    logic [NUM_HOST-1:0] acc_host;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ORDER_W-1:0]  fifo_rd;
    logic [3:0]          pop_type;
    logic [NUM_HOST-1:0] pop_host;

    sched_state_e        state_q;
    sched_state_e        state_d;
    logic [WD_W-1:0]     watchdog;
    logic                wd_expired;
    logic [3:0]          cur_type;

    // Search starts at the round-robin pointer and wraps; a full queue withholds every grant.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        grant_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx -= NUM_REQ;
            end
            if (!grant_found && req_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
        if (grant_found && !fifo_full) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready_o = grant;
    assign accept      = |grant;
    assign acc_type    = req_type_i[grant_idx*4 +: 4];
    assign acc_host    = req_host_i[grant_idx*NUM_HOST +: NUM_HOST];
    assign next_ptr    = (grant_idx == NUM_REQ - 1) ? '0 : PTR_W'(grant_idx + 1);
    assign pop_type    = fifo_rd[ORDER_W-1 -: 4];
    assign pop_host    = fifo_rd[NUM_HOST-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= next_ptr;
        end
    end

`ifdef HB_COALESCE_EN
    logic [2**NUM_HOST-1:0] hb_pending;
    logic                   pop_hb;
    logic                   hb_drop;

    // A same-cycle pop of this host's heartbeat frees the slot, so the new one is queued instead of dropped.
    assign pop_hb    = fifo_pop && (pop_type == MSG_HEARTBEAT);
    assign hb_drop   = (acc_type == MSG_HEARTBEAT) && hb_pending[acc_host] &&
                       !(pop_hb && (pop_host == acc_host));
    assign fifo_push = accept && !hb_drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hb_pending <= '0;
        end else begin
            if (pop_hb) begin
                hb_pending[pop_host] <= 1'b0;
            end
            if (fifo_push && (acc_type == MSG_HEARTBEAT)) begin
                hb_pending[acc_host] <= 1'b1;
            end
        end
    end
`else
    assign fifo_push = accept;
`endif

    sync_fifo #(
        .WIDTH (ORDER_W),
        .DEPTH (FIFO_DEPTH)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({acc_type, acc_host}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wd_expired = (watchdog == WD_W'(DONE_TMO));
    assign busy_o     = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_LOOKUP;
                end
            end
            ST_LOOKUP:  state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (cm_done_i || wd_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // addr_o doubles as the latched host of the order in flight until it is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_o             <= '0;
            cur_type           <= '0;
            initiate_msg_o     <= 1'b0;
            create_message_o   <= '0;
            targetCompId_o     <= '0;
            s_v_targetCompId_o <= '0;
            host_o             <= '0;
            tmo_err_o          <= 1'b0;
            watchdog           <= '0;
        end else begin
            initiate_msg_o <= 1'b0;
            tmo_err_o      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        addr_o   <= pop_host;
                        cur_type <= pop_type;
                    end
                end
                ST_ISSUE: begin
                    targetCompId_o     <= data_i[VALUE_WIDTH-1:0];
                    s_v_targetCompId_o <= data_i[VALUE_WIDTH+SIZE-1:VALUE_WIDTH];
                    create_message_o   <= cur_type;
                    host_o             <= addr_o;
                    initiate_msg_o     <= 1'b1;
                    watchdog           <= '0;
                end
                ST_WAIT_DONE: begin
                    if (!cm_done_i) begin
                        if (wd_expired) begin
                            tmo_err_o <= 1'b1;
                        end else begin
                            watchdog <= watchdog + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
